// File: rtl/delay_pkg.sv
// Shared types and sizing helpers for the tap multiply-accumulate filter.
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Full-precision dot-product width: one product plus growth for N terms.
    function automatic int acc_width(input int width, input int cw, input int n);
        return width + cw + $clog2(n);
    endfunction

    // Index counter width; never zero so a single-tap filter still has a counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module tap_mac
    import delay_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = 16,
    parameter int AW    = 35
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [WIDTH-1:0]  a,
    input  logic [CW-1:0]     b,
    output logic [AW-1:0]     acc
);

    localparam int PW = WIDTH + CW;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;

    // Operands widened to the product width first so the multiply is exact.
    assign prod     = PW'($signed(a)) * PW'($signed(b));
    assign prod_ext = AW'(prod);

    // Accumulate one product per enabled cycle; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/tap_mac_filter.sv
// Serial signed dot product of a snapshot of the delay-line taps against a
// snapshot of the coefficients, one MAC per cycle, result flagged by valid.
module tap_mac_filter
    import delay_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DELAY = 7,
    parameter int CW    = 16,
    parameter int AW    = acc_width(WIDTH, CW, DELAY + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH*(DELAY+1)-1:0] taps,
    input  logic [CW*(DELAY+1)-1:0]    coefs,
    output logic                       busy,
    output logic [AW-1:0]              result,
    output logic                       valid,
    output logic                       overrun
);

    localparam int N      = DELAY + 1;
    localparam int IW     = idx_width(N);
    localparam int AW_MIN = acc_width(WIDTH, CW, N);

    // A narrower accumulator could silently wrap, so refuse to elaborate.
    if (AW < AW_MIN) begin : g_aw_check
        $error("tap_mac_filter: AW smaller than full-precision width");
    end

    typedef logic [IW-1:0] idx_t;

    state_t                     state;
    state_t                     state_next;
    idx_t                       idx;
    logic [N-1:0][WIDTH-1:0]    tap_snap;
    logic [N-1:0][CW-1:0]       coef_snap;
    logic [AW-1:0]              acc;
    logic [AW-1:0]              result_q;
    logic                       overrun_q;
    logic                       capture;
    logic                       last;

    // New work is accepted when idle or in the result cycle (back-to-back).
    assign capture = start && ((state == IDLE) || (state == DONE));
    assign last    = (idx == idx_t'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: RUN for exactly N cycles, then a single DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Freeze the inputs at capture so the upstream chain can keep shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_snap  <= '0;
            coef_snap <= '0;
        end else if (capture) begin
            tap_snap  <= taps;
            coef_snap <= coefs;
        end
    end

    // Tap index walks 0..N-1 during RUN and parks at 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (state == RUN) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    tap_mac #(
        .WIDTH (WIDTH),
        .CW    (CW),
        .AW    (AW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (capture),
        .en  (state == RUN),
        .a   (tap_snap[idx]),
        .b   (coef_snap[idx]),
        .acc (acc)
    );

    // Retire the finished sum so result holds after the accumulator is reused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (state == DONE) begin
            result_q <= acc;
        end
    end

    // A start that lands mid-computation is dropped and flagged next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= start && (state == RUN);
        end
    end

    assign busy    = (state != IDLE);
    assign valid   = (state == DONE);
    assign result  = valid ? acc : result_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_tap_mac_filter.sv
// Scoreboard bench: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and compares whenever valid is presented.
module tb_tap_mac_filter;

    localparam int WIDTH = 8;
    localparam int CW    = 8;
    localparam int DELAY = 3;
    localparam int N     = DELAY + 1;
    localparam int AW    = WIDTH + CW + $clog2(N);

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH*N-1:0]   taps;
    logic [CW*N-1:0]      coefs;
    logic                 busy;
    logic [AW-1:0]        result;
    logic                 valid;
    logic                 overrun;

    typedef struct {
        logic signed [AW-1:0] res;
        int                   cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;

    tap_mac_filter #(
        .WIDTH (WIDTH),
        .DELAY (DELAY),
        .CW    (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .taps    (taps),
        .coefs   (coefs),
        .busy    (busy),
        .result  (result),
        .valid   (valid),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start, let the edge sample them, then queue the
    // expected sum due N cycles after the sampling edge.
    task automatic do_start(input logic [31:0] t, input logic [31:0] c, input int exp);
        exp_t e;
        taps  = t;
        coefs = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        e.res = AW'(exp);
        e.cyc = cnt + N;
        q.push_back(e);
    endtask

    // Monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got result %0d at cycle %0d expected no valid",
                         $signed(result), cnt);
            end else begin
                e = q.pop_front();
                if ($signed(result) !== e.res || cnt != e.cyc) begin
                    bad++;
                    $display("FAIL result: got %0d at cycle %0d expected %0d at cycle %0d",
                             $signed(result), cnt, e.res, e.cyc);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        taps  = '0;
        coefs = '0;
        repeat (2) tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_result", $signed(result), 0);
        rst = 1'b0;
        tick();

        // Basic sum and busy profile: busy through RUN and DONE, then low.
        do_start(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 10);
        for (int i = 0; i < N + 1; i++) begin
            chk("busy_active", 32'(busy), 1);
            tick();
        end
        chk("busy_idle", 32'(busy), 0);
        chk("result_hold", $signed(result), 10);

        // Signed extremes must not wrap.
        do_start(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 65536);
        repeat (6) tick();
        do_start(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), -65024);
        repeat (6) tick();

        // Inputs changing during RUN are ignored.
        do_start(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 10);
        taps  = pk(9, 9, 9, 9);
        coefs = pk(3, 3, 3, 3);
        repeat (6) tick();

        // Back-to-back: second start held through the DONE cycle.
        do_start(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 10);
        repeat (N) tick();
        chk("b2b_done", 32'(valid), 1);
        do_start(pk(5, 0, 0, 0), pk(2, 0, 0, 0), 10);
        repeat (6) tick();

        // Overrun: start during RUN is dropped and flagged for one cycle.
        do_start(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 10);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("overrun_pulse", 32'(overrun), 1);
        tick();
        chk("overrun_clear", 32'(overrun), 0);
        repeat (6) tick();

        // Reset mid-RUN discards the computation.
        do_start(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 10);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_result", $signed(result), 0);
        void'(q.pop_back());
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // Fresh computation after reset release, mixed signs.
        do_start(pk(2, -3, 4, -5), pk(7, 6, -5, 4), -44);
        repeat (6) tick();
        chk("final_hold", $signed(result), -44);

        // Drain with a bound.
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
